// File: rtl/mdu_seq.sv
// Sequential radix-2 shift-add multiplier for mult/multu with HI/LO registers.
// Reads of HI/LO stall the pipeline while a multiply is in flight.
module mdu_seq #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         rd_req,
    input  logic         rd_hi,
    output logic [n-1:0] rd_data,
    output logic         busy,
    output logic         done,
    output logic         stall
);

    localparam int cw = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [cw-1:0]    count;
    logic [2*n-1:0]   acc;
    logic [2*n-1:0]   mcand_sh;
    logic [2*n-1:0]   product;
    logic [n-1:0]     mplier;
    logic [n-1:0]     hi, lo;
    logic [n-1:0]     a_mag, b_mag;
    logic             neg;

    // Signed operands become magnitudes; -2^(n-1) maps to 2^(n-1) as unsigned.
    assign a_mag   = (is_signed && a[n-1]) ? -a : a;
    assign b_mag   = (is_signed && b[n-1]) ? -b : b;
    assign product = neg ? -acc : acc;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == cw'(n - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        acc      <= '0;
                        mcand_sh <= {{n{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        neg      <= is_signed & (a[n-1] ^ b[n-1]);
                    end
                end
                RUN: begin
                    // Multiplicand shifts left while multiplier shifts right, so bit 0 is always current.
                    if (mplier[0]) acc <= acc + mcand_sh;
                    mcand_sh <= mcand_sh << 1;
                    mplier   <= mplier >> 1;
                    count    <= count + cw'(1);
                end
                DONE: begin
                    hi <= product[2*n-1:n];
                    lo <= product[n-1:0];
                end
                default: ;
            endcase
        end
    end

    // Status outputs are forced low while reset is asserted, whatever the state.
    assign busy    = (state != IDLE) && !reset;
    assign done    = (state == DONE) && !reset;
    assign stall   = rd_req && busy;
    assign rd_data = rd_hi ? hi : lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: result values, latency, interlock, ignored start and reset.
module tb_mdu_seq;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset, start, is_signed, rd_req, rd_hi;
    logic [N-1:0] a, b, rd_data;
    logic         busy, done, stall;

    int total  = 0;
    int passed = 0;

    int           doneCyc, doneCnt, stallBad;
    logic         busy1, busy34, busyRst;
    logic [N-1:0] rd33, rd34, hiVal, loVal;

    always #5 clk = ~clk;

    mdu_seq #(.n(N)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .rd_req(rd_req), .rd_hi(rd_hi),
        .rd_data(rd_data), .busy(busy), .done(done), .stall(stall)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic readHiLo(output logic [N-1:0] hv, output logic [N-1:0] lv);
        rd_hi = 1'b1;
        #1 hv = rd_data;
        rd_hi = 1'b0;
        #1 lv = rd_data;
    endtask

    // Cycle k is the period after the k-th clock edge following the start edge (cycle 0 holds start).
    task automatic applyStimulus(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tsgn,
                                 input int lateCyc, input int rstCyc, input logic holdRead);
        @(negedge clk);
        a = ta; b = tb; is_signed = tsgn; start = 1'b1;
        if (holdRead) begin rd_req = 1'b1; rd_hi = 1'b0; end
        doneCyc = 0; doneCnt = 0; stallBad = 0;
        busy1 = 1'b0; busy34 = 1'b1; busyRst = 1'b1; rd33 = '0; rd34 = '0;
        for (int cyc = 1; cyc <= 52; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start = 1'b0; busy1 = busy; end
            if (done) begin
                doneCnt++;
                if (doneCyc == 0) doneCyc = cyc;
            end
            if (holdRead && cyc <= 34 && stall !== (cyc <= 33)) stallBad++;
            if (cyc == 33) rd33 = rd_data;
            if (cyc == 34) begin rd34 = rd_data; busy34 = busy; rd_req = 1'b0; end
            if (lateCyc != 0 && cyc == lateCyc) begin
                a = 32'd100; b = 32'd100; is_signed = 1'b1; start = 1'b1;
            end
            if (lateCyc != 0 && cyc == lateCyc + 1) start = 1'b0;
            if (rstCyc != 0 && cyc == rstCyc) reset = 1'b1;
            if (rstCyc != 0 && cyc == rstCyc + 1) begin busyRst = busy; reset = 1'b0; end
        end
        readHiLo(hiVal, loVal);
    endtask

    initial begin
        int dcount;
        bit seen;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; rd_req = 1'b0; rd_hi = 1'b0;
        a = '0; b = '0;

        // Reset behaviour: status low during reset, HI/LO zero after.
        repeat (2) @(negedge clk);
        rd_req = 1'b1;
        #1;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst stall", stall, 0);
        @(negedge clk);
        reset = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        readHiLo(hiVal, loVal);
        checkOutput("rst hi", hiVal, 0);
        checkOutput("rst lo", loVal, 0);
        checkOutput("rst busy after", busy, 0);

        // Unsigned max*max with interlocked mflo held across the operation.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1);
        checkOutput("umax done cycle", doneCyc, 33);
        checkOutput("umax done count", doneCnt, 1);
        checkOutput("umax busy cyc1", busy1, 1);
        checkOutput("umax busy cyc34", busy34, 0);
        checkOutput("interlock stall pattern errors", stallBad, 0);
        checkOutput("interlock old lo at done", rd33, 32'h0);
        checkOutput("interlock new lo", rd34, 32'h1);
        checkOutput("umax hi", hiVal, 32'hFFFF_FFFE);
        checkOutput("umax lo", loVal, 32'h0000_0001);

        // Signed -3 * 7 = -21.
        applyStimulus(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0, 0, 1'b0);
        checkOutput("s neg done cycle", doneCyc, 33);
        checkOutput("s neg hi", hiVal, 32'hFFFF_FFFF);
        checkOutput("s neg lo", loVal, 32'hFFFF_FFEB);

        // Signed boundary -2^31 * -1 = +2^31.
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);
        checkOutput("s min hi", hiVal, 32'h0000_0000);
        checkOutput("s min lo", loVal, 32'h8000_0000);

        // Same operands unsigned: 2^31 * (2^32-1) = 2^63 - 2^31.
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0);
        checkOutput("u min hi", hiVal, 32'h7FFF_FFFF);
        checkOutput("u min lo", loVal, 32'h8000_0000);

        // Zero operand still takes the full latency.
        applyStimulus(32'h0, 32'h5, 1'b0, 0, 0, 1'b0);
        checkOutput("zero done cycle", doneCyc, 33);
        checkOutput("zero hi", hiVal, 32'h0);
        checkOutput("zero lo", loVal, 32'h0);

        // Second start at cycle 5 must be ignored.
        applyStimulus(32'd6, 32'd7, 1'b0, 5, 0, 1'b0);
        checkOutput("ignore done count", doneCnt, 1);
        checkOutput("ignore done cycle", doneCyc, 33);
        checkOutput("ignore hi", hiVal, 32'h0);
        checkOutput("ignore lo", loVal, 32'd42);

        // Load HI=0x12345678, LO=0 for the read-before-write case.
        applyStimulus(32'h2468_ACF0, 32'h8000_0000, 1'b0, 0, 0, 1'b0);
        checkOutput("setup hi", hiVal, 32'h1234_5678);
        checkOutput("setup lo", loVal, 32'h0);

        // Start and mfhi in the same IDLE cycle: no stall, old HI returned.
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; is_signed = 1'b0;
        start = 1'b1; rd_req = 1'b1; rd_hi = 1'b1;
        #1;
        checkOutput("same-cycle stall", stall, 0);
        checkOutput("same-cycle rd_data", rd_data, 32'h1234_5678);
        @(negedge clk);
        start = 1'b0; rd_req = 1'b0; rd_hi = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("same-cycle op finished", seen, 1);
        @(negedge clk);
        readHiLo(hiVal, loVal);
        checkOutput("same-cycle new hi", hiVal, 32'hFFFF_FFFE);
        checkOutput("same-cycle new lo", loVal, 32'h0000_0001);

        // Reset during RUN aborts the op and clears HI/LO.
        applyStimulus(32'd3, 32'd5, 1'b0, 0, 10, 1'b0);
        checkOutput("abort done count", doneCnt, 0);
        checkOutput("abort busy after reset", busyRst, 0);
        checkOutput("abort hi", hiVal, 32'h0);
        checkOutput("abort lo", loVal, 32'h0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        checkOutput("rst-start busy", busy, 0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("rst-start done count", dcount, 0);
        readHiLo(hiVal, loVal);
        checkOutput("rst-start lo", loVal, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
